// File: rtl/alu_pkg.sv
// Shared definitions for the ALU responder: op codes, FSM states and the default width.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 6;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_OXA = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StMul  = 2'b10,
        StDone = 2'b11
    } alu_state_e;

endpackage

// File: rtl/alu_shift_mult.sv
// Iterative shift-add multiplier: one partial product per clock, MUL_CYCLES iterations per start.
module alu_shift_mult #(
    parameter int unsigned WIDTH      = 6,
    parameter int unsigned MUL_CYCLES = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);

    logic                running_q, running_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [2*WIDTH-1:0]  partial;

    always_comb begin
        partial   = {{WIDTH{1'b0}}, a_i} << cnt_q;
        running_d = running_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        done_o    = 1'b0;
        if (start_i) begin
            running_d = 1'b1;
            cnt_d     = '0;
            acc_d     = '0;
        end else if (running_q) begin
            if (b_i[cnt_q]) begin
                acc_d = acc_q + partial;
            end
            cnt_d = cnt_q + 1'b1;
            // Last iteration: the responder captures product_o on this same edge.
            if (cnt_q == CntLast) begin
                done_o    = 1'b1;
                running_d = 1'b0;
            end
        end
        product_o = acc_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
        end else begin
            running_q <= running_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
        end
    end

endmodule

// File: rtl/alu_responder.sv
// Multi-cycle ALU serving controller requests: latches operands, runs add/oxa/sub in one
// cycle or multiply iteratively, then pulses alu_done with registered alu_out/alu_flag.
module alu_responder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = ALU_WIDTH,
    parameter int unsigned MUL_CYCLES = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_req,
    input  logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_in2,
    input  logic [1:0]       alu_op,
    output logic             alu_busy,
    output logic             alu_done,
    output logic [WIDTH-1:0] alu_out,
    output logic             alu_flag
);

    alu_state_e        state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              flag_q, flag_d;

    logic                mul_start;
    logic                mul_done;
    logic [2*WIDTH-1:0]  mul_prod;

    logic [WIDTH-1:0]  sum;
    logic [WIDTH:0]    diff;
    logic [WIDTH-1:0]  exec_res;
    logic              exec_flag;

    alu_shift_mult #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_shift_mult (
        .clk_i     (clk),
        .rst_ni    (reset),
        .start_i   (mul_start),
        .a_i       (a_q),
        .b_i       (b_q),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    // Single-cycle ops; diff carries the borrow in its top bit.
    always_comb begin
        sum       = a_q + b_q;
        diff      = {1'b0, a_q} - {1'b0, b_q};
        exec_res  = '0;
        exec_flag = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                exec_res  = sum;
                exec_flag = |sum;
            end
            OP_OXA: begin
                exec_res  = (a_q | b_q) ^ (a_q & b_q);
                exec_flag = |exec_res;
            end
            OP_SUB: begin
                exec_res  = diff[WIDTH-1:0];
                exec_flag = diff[WIDTH];
            end
            default: begin
                exec_res  = '0;
                exec_flag = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        out_d     = out_q;
        flag_d    = flag_q;
        mul_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (alu_req) begin
                    a_d  = alu_in1;
                    b_d  = alu_in2;
                    op_d = alu_op;
                    if (alu_op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = StMul;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                out_d   = exec_res;
                flag_d  = exec_flag;
                state_d = StDone;
            end
            StMul: begin
                if (mul_done) begin
                    out_d   = mul_prod[WIDTH-1:0];
                    flag_d  = |mul_prod[2*WIDTH-1:WIDTH];
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            out_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            out_q   <= out_d;
            flag_q  <= flag_d;
        end
    end

    assign alu_busy = (state_q != StIdle);
    assign alu_done = (state_q == StDone);
    assign alu_out  = out_q;
    assign alu_flag = flag_q;

endmodule

// File: tb/tb_alu_responder.sv
// Self-checking bench for alu_responder: directed boundary cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_responder;

    logic       clk;
    logic       reset;
    logic       alu_req;
    logic [5:0] alu_in1;
    logic [5:0] alu_in2;
    logic [1:0] alu_op;
    logic       alu_busy;
    logic       alu_done;
    logic [5:0] alu_out;
    logic       alu_flag;

    int tests = 0;
    int fails = 0;

    alu_responder dut (
        .clk      (clk),
        .reset    (reset),
        .alu_req  (alu_req),
        .alu_in1  (alu_in1),
        .alu_in2  (alu_in2),
        .alu_op   (alu_op),
        .alu_busy (alu_busy),
        .alu_done (alu_done),
        .alu_out  (alu_out),
        .alu_flag (alu_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model straight from the arithmetic rules.
    function automatic void model(input int a, input int b, input int op,
                                  output int r, output int f);
        int p;
        case (op)
            0: begin r = (a + b) % 64; f = (r != 0) ? 1 : 0; end
            1: begin r = (a | b) ^ (a & b); f = (r != 0) ? 1 : 0; end
            2: begin r = (a - b + 64) % 64; f = (a < b) ? 1 : 0; end
            default: begin p = a * b; r = p % 64; f = (p >= 64) ? 1 : 0; end
        endcase
    endfunction

    // mode 0: plain; 1: scramble inputs after accept; 2: extra req pulse while busy
    task automatic run_op(input string tag, input int a, input int b, input int op,
                          input int mode);
        int r, f, n, lat;
        model(a, b, op, r, f);
        lat = (op == 3) ? 6 : 1;
        @(negedge clk);
        alu_in1 = 6'(a);
        alu_in2 = 6'(b);
        alu_op  = 2'(op);
        alu_req = 1'b1;
        @(posedge clk);
        #1;
        alu_req = 1'b0;
        check({tag, "_busy_accept"}, 32'(alu_busy), 1);
        if (mode == 1) begin
            alu_in1 = 6'($urandom);
            alu_in2 = 6'($urandom);
            alu_op  = 2'($urandom);
        end
        n = 0;
        while (!alu_done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (mode == 2 && n == 2) begin
                alu_req = 1'b1;
                alu_in1 = 6'(a ^ 21);
                alu_in2 = 6'(b ^ 42);
                alu_op  = 2'(op ^ 1);
            end
            if (mode == 2 && n == 4) alu_req = 1'b0;
        end
        alu_req = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_out"}, 32'(alu_out), 32'(r));
        check({tag, "_flag"}, 32'(alu_flag), 32'(f));
        check({tag, "_busy_done"}, 32'(alu_busy), 1);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(alu_done), 0);
        check({tag, "_busy_idle"}, 32'(alu_busy), 0);
        if (mode == 2) begin
            @(posedge clk);
            #1;
            check({tag, "_not_queued"}, 32'(alu_busy), 0);
        end
    endtask

    initial begin
        int hold_out, hold_flag;
        int ra, rb, rop;
        reset   = 1'b0;
        alu_req = 1'b0;
        alu_in1 = '0;
        alu_in2 = '0;
        alu_op  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(alu_busy), 0);
        check("rst_done", 32'(alu_done), 0);
        check("rst_out", 32'(alu_out), 0);
        check("rst_flag", 32'(alu_flag), 0);
        @(negedge clk);
        reset = 1'b1;

        run_op("add_5_3", 5, 3, 0, 0);
        run_op("add_0_0", 0, 0, 0, 0);
        run_op("oxa_10_7", 10, 7, 1, 0);
        run_op("add_wrap", 63, 1, 0, 0);
        run_op("sub_borrow", 0, 1, 2, 0);
        run_op("sub_9_4", 9, 4, 2, 1);
        run_op("mul_7_6", 7, 6, 3, 0);
        run_op("mul_63_63", 63, 63, 3, 1);
        run_op("mul_by_0", 45, 0, 3, 0);
        run_op("mul_ignore_req", 11, 5, 3, 2);

        // Reset partway through a multiply.
        @(negedge clk);
        alu_in1 = 6'd13;
        alu_in2 = 6'd9;
        alu_op  = 2'd3;
        alu_req = 1'b1;
        @(posedge clk);
        #1;
        alu_req = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(alu_busy), 0);
        check("abort_done", 32'(alu_done), 0);
        check("abort_out", 32'(alu_out), 0);
        check("abort_flag", 32'(alu_flag), 0);
        repeat (8) begin
            @(posedge clk);
            #1;
            check("abort_no_done", 32'(alu_done), 0);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("abort_idle", 32'(alu_busy), 0);
        end
        run_op("after_abort", 20, 3, 3, 0);

        // Outputs hold while idle with changing inputs.
        hold_out  = int'(alu_out);
        hold_flag = int'(alu_flag);
        repeat (10) begin
            @(negedge clk);
            alu_in1 = 6'($urandom);
            alu_in2 = 6'($urandom);
            alu_op  = 2'($urandom);
            @(posedge clk);
            #1;
            check("hold_out", 32'(alu_out), 32'(hold_out));
            check("hold_flag", 32'(alu_flag), 32'(hold_flag));
            check("hold_done", 32'(alu_done), 0);
        end

        for (int i = 0; i < 40; i++) begin
            ra  = int'($urandom_range(63, 0));
            rb  = int'($urandom_range(63, 0));
            rop = int'($urandom_range(3, 0));
            run_op("rand", ra, rb, rop, int'($urandom_range(2, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_responder.md
Name: alu_responder

Overview:
Multi-cycle ALU that serves requests from the controller over the alu_in1/alu_in2/alu_op interface. It sits between the controller and the datapath. It latches operands on a request and executes one of four 6-bit operations: add, OR_XOR_AND, subtract, or iterative shift-add multiply. It returns alu_out/alu_flag together with a one-cycle done pulse, and reports busy while executing.

Parameters:
WIDTH, 6, operand and result width
MUL_CYCLES, 6, shift-add iterations for op 11; must equal WIDTH

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
alu_req  input  1  request strobe from controller; sampled only in IDLE
alu_in1  input  WIDTH  operand A; captured on accept
alu_in2  input  WIDTH  operand B; captured on accept
alu_op  input  2  operation select; captured on accept
alu_busy  output  1  high from the accept edge until the DONE state is left
alu_done  output  1  one-cycle pulse; alu_out/alu_flag are valid and stable in that cycle
alu_out  output  WIDTH  registered result; holds until the next completion
alu_flag  output  1  registered flag; holds until the next completion

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; alu_busy=0, alu_done=0, alu_out=0, alu_flag=0; operand, op, counter and accumulator registers cleared.
- Reset asserted mid-operation: operation aborted, no done pulse, outputs forced to reset values. After release, the block waits in IDLE.
- States: IDLE, EXEC, MUL, DONE.
- IDLE: if alu_req=1 at edge k, latch operands and op, set alu_busy=1.
  - op 00/01/10 -> EXEC.
  - op 11 -> MUL, with counter=0 and acc=0.
- EXEC: one cycle. Compute result, register alu_out/alu_flag at edge k+1 -> DONE.
- MUL: one shift-add iteration per edge.
  - If B[counter]=1, acc += A<<counter. Acc is 2*WIDTH bits.
  - After MUL_CYCLES iterations (edge k+6), register outputs -> DONE.
- DONE: alu_done=1 for exactly one cycle, then -> IDLE and alu_busy=0 at the next edge.
- Latency, request edge to done cycle: 2 cycles for ops 00/01/10; 7 cycles for op 11.
- alu_req while busy (EXEC/MUL/DONE) is ignored and not queued.
  - Back-to-back requests need req high in IDLE.
  - Minimum issue interval: 3 cycles for simple ops, 8 cycles for multiply.
- Input changes after accept have no effect on the operation in progress.
- Arithmetic (all results truncated to WIDTH bits):
  - 00 add: out = (A+B) mod 64; flag = (out != 0).
  - 01 OR_XOR_AND: out = (A|B) ^ (A&B); flag = (out != 0).
  - 10 subtract: out = (A-B) mod 64; flag = borrow, i.e. A<B.
  - 11 multiply: out = product[5:0]; flag = |product[11:6] (overflow).
- Boundaries:
  - 63+1 -> out=0, flag=0.
  - 0-1 -> out=63, flag=1.
  - 63*63 -> out=1, flag=1.
  - Multiply by 0 still takes the full MUL_CYCLES.

Decomposition:
- Shared package alu_pkg holds:
  - op-code constants OP_ADD=2'b00, OP_OXA=2'b01, OP_SUB=2'b10, OP_MUL=2'b11;
  - state encoding IDLE/EXEC/MUL/DONE;
  - WIDTH default.
- One natural sub-module: alu_shift_mult.
  - Owns counter, accumulator and iteration control.
  - start/done interface toward the responder FSM.

Test Plan:
- Reset mid-op: hold reset=0 -> all outputs 0. Release, then alu_req with A=5, B=3, op=00 -> done 2 cycles later, alu_out=8, alu_flag=1, busy high through done cycle.
- Add and OR_XOR_AND: A=0, B=0, op=00 -> out=0, flag=0. A=10, B=7, op=01 -> out=13, flag=1.
- Wrap and borrow: A=63, B=1, op=00 -> out=0, flag=0. A=0, B=1, op=10 -> out=63, flag=1. A=9, B=4, op=10 -> out=5, flag=0.
- Multiply: A=7, B=6, op=11 -> done exactly 7 cycles after accept, out=42, flag=0. A=63, B=63 -> out=1, flag=1.
- Busy/abort: alu_req pulsed during MUL with different operands -> ignored, result unchanged. Reset asserted at MUL iteration 3 -> no done pulse, outputs 0, next request serviced normally.
- Hold: after a completion, inputs toggled with alu_req=0 for 10 cycles -> alu_out/alu_flag unchanged, alu_done stays 0.
